// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, legal range, FSM states
// and instruction field layout.
package alu_pkg;

    localparam int NREGS  = 16;
    localparam int XLEN   = 32;
    localparam int RIDX_W = 4;
    localparam int OPC_W  = 6;

    localparam logic [OPC_W-1:0] OP_ADD = 6'd4;
    localparam logic [OPC_W-1:0] OP_SUB = 6'd5;
    localparam logic [OPC_W-1:0] OP_NEG = 6'd6;
    localparam logic [OPC_W-1:0] OP_AVG = 6'd7;
    localparam logic [OPC_W-1:0] OP_ABS = 6'd8;
    localparam logic [OPC_W-1:0] OP_NOT = 6'd9;
    localparam logic [OPC_W-1:0] OP_AND = 6'd10;
    localparam logic [OPC_W-1:0] OP_OR  = 6'd11;
    localparam logic [OPC_W-1:0] OP_XOR = 6'd12;
    localparam logic [OPC_W-1:0] OP_MAX = 6'd13;
    localparam logic [OPC_W-1:0] OP_MIN = 6'd14;

    localparam logic [OPC_W-1:0] OP_LEGAL_LO = OP_ADD;
    localparam logic [OPC_W-1:0] OP_LEGAL_HI = OP_MIN;

    localparam int OPC_LO = 26;
    localparam int RD_LO  = 22;
    localparam int RS1_LO = 18;
    localparam int RS2_LO = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE
    } state_t;

    typedef struct packed {
        logic [OPC_W-1:0]  opc;
        logic [RIDX_W-1:0] rd;
        logic [RIDX_W-1:0] rs1;
        logic [RIDX_W-1:0] rs2;
    } instr_t;

    function automatic instr_t decode(input logic [XLEN-1:0] w);
        instr_t d;
        d.opc = w[OPC_LO +: OPC_W];
        d.rd  = w[RD_LO  +: RIDX_W];
        d.rs1 = w[RS1_LO +: RIDX_W];
        d.rs2 = w[RS2_LO +: RIDX_W];
        return d;
    endfunction

    function automatic logic op_legal(input logic [OPC_W-1:0] op);
        return (op >= OP_LEGAL_LO) && (op <= OP_LEGAL_HI);
    endfunction

endpackage

// File: rtl/alu_reg_file.sv
// 16 x 32-bit register file: two operand read ports, one debug read port and
// one write port. Index 0 always reads zero and is never written.
module alu_reg_file
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [RIDX_W-1:0] ra_addr,
    output logic [XLEN-1:0]   ra_data,
    input  logic [RIDX_W-1:0] rb_addr,
    output logic [XLEN-1:0]   rb_data,
    input  logic [RIDX_W-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data,
    input  logic              we,
    input  logic [RIDX_W-1:0] wa,
    input  logic [XLEN-1:0]   wd
);

    logic [XLEN-1:0] rf [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (we && (wa != '0)) begin
            rf[wa] <= wd;
        end
    end

    assign ra_data  = (ra_addr  == '0) ? '0 : rf[ra_addr];
    assign rb_data  = (rb_addr  == '0) ? '0 : rf[rb_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Sequences one instruction at a time through READ/EXEC/WRITE around an
// external combinational ALU and writes the result back to the register file.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_instr,
    output logic              in_ready,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    input  logic [XLEN-1:0]   alu_result,
    output logic              done_valid,
    output logic [XLEN-1:0]   done_result,
    output logic [RIDX_W-1:0] done_rd,
    output logic              done_illegal,
    input  logic [RIDX_W-1:0] dbg_addr,
    output logic [XLEN-1:0]   dbg_data
);

    state_t          state;
    instr_t          cur;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            rf_we;
    logic            unused_instr_low;

    assign unused_instr_low = ^in_instr[RS2_LO-1:0];

    assign in_ready = (state == ST_IDLE);

    // Writeback happens while done_valid is high, so done_result is the data
    // and done_illegal suppresses the write.
    assign rf_we = (state == ST_WRITE) && !done_illegal;

    alu_reg_file u_rf (
        .clk      (clk),
        .reset    (reset),
        .ra_addr  (cur.rs1),
        .ra_data  (rs1_val),
        .rb_addr  (cur.rs2),
        .rb_data  (rs2_val),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .wa       (cur.rd),
        .wd       (done_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cur          <= '0;
            alu_opcode   <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            done_valid   <= 1'b0;
            done_result  <= '0;
            done_rd      <= '0;
            done_illegal <= 1'b0;
        end else begin
            done_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        cur        <= decode(in_instr);
                        alu_opcode <= in_instr[OPC_LO +: OPC_W];
                        state      <= ST_READ;
                    end
                end
                ST_READ: begin
                    alu_a <= rs1_val;
                    alu_b <= rs2_val;
                    if (op_legal(cur.opc)) begin
                        state <= ST_EXEC;
                    end else begin
                        done_valid   <= 1'b1;
                        done_result  <= '0;
                        done_rd      <= cur.rd;
                        done_illegal <= 1'b1;
                        state        <= ST_WRITE;
                    end
                end
                ST_EXEC: begin
                    done_valid   <= 1'b1;
                    done_result  <= alu_result;
                    done_rd      <= cur.rd;
                    done_illegal <= 1'b0;
                    state        <= ST_WRITE;
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
